// File: rtl/fpmul_result_sink.sv
// Capture sink behind the pipelined FP multiplier: realigns VIN to LATENCY, buffers FP_Z results, counts samples, raises END_SIM.
// Optional result classification counters (NaN/Inf/zero) are enabled by defining FPSINK_CLASS_EN.
module fpmul_result_sink #(
  parameter int LATENCY   = 4,
  parameter int DEPTH     = 16,
  parameter int N_SAMPLES = 10000,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VIN,
  input  logic [31:0]      DIN,
  input  logic             RD_EN,
  output logic [31:0]      DOUT,
  output logic             DOUT_VALID,
  output logic             EMPTY,
  output logic             FULL,
  output logic             OVERFLOW,
  output logic [CNT_W-1:0] SAMPLE_CNT,
  output logic             END_SIM
`ifdef FPSINK_CLASS_EN
  ,
  output logic [CNT_W-1:0] NAN_CNT,
  output logic [CNT_W-1:0] INF_CNT,
  output logic [CNT_W-1:0] ZERO_CNT
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(N_SAMPLES - 1);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);
  localparam logic [AW:0]      LP_PONE = (AW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LATENCY-1:0] r_vsr;
  logic               w_cap;
  logic               w_count;
  logic               w_last;
  logic               w_rd;
  logic               w_wr;
  logic               w_drop;
  logic [AW:0]        r_wptr;
  logic [AW:0]        r_rptr;
  logic [AW:0]        w_wptr_nxt;
  logic [AW:0]        w_rptr_nxt;
  logic               w_empty_nxt;
  logic               w_full_nxt;
  logic [31:0]        r_mem [DEPTH];
  logic [31:0]        r_dout;
  logic               r_dout_vld;
  logic               r_empty;
  logic               r_full;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_sample_cnt;
  logic               r_end_sim;

  // VIN delay line; its last stage marks the edge where DIN carries the matching result
  generate
    if (LATENCY == 1) begin : g_vsr_one
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_vsr <= '0;
        else     r_vsr <= VIN;
      end
    end else begin : g_vsr_multi
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_vsr <= '0;
        else     r_vsr <= {r_vsr[LATENCY-2:0], VIN};
      end
    end
  endgenerate

  assign w_cap  = r_vsr[LATENCY-1];
  assign w_last = (r_sample_cnt == LP_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cap) begin
          w_count     = 1'b1;
          w_state_nxt = w_last ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_cap) begin
          w_count = 1'b1;
          if (w_last) w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A same-cycle read frees the slot a full-FIFO write needs; an empty FIFO never bypasses
  assign w_rd   = RD_EN & ~r_empty;
  assign w_wr   = w_count & (~r_full | w_rd);
  assign w_drop = w_count & ~w_wr;

  assign w_wptr_nxt  = w_wr ? (r_wptr + LP_PONE) : r_wptr;
  assign w_rptr_nxt  = w_rd ? (r_rptr + LP_PONE) : r_rptr;
  assign w_empty_nxt = (w_wptr_nxt == w_rptr_nxt);
  assign w_full_nxt  = (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                       (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);

  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= DIN;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_empty      <= 1'b1;
      r_full       <= 1'b0;
      r_dout       <= '0;
      r_dout_vld   <= 1'b0;
      r_ovf        <= 1'b0;
      r_sample_cnt <= '0;
      r_end_sim    <= 1'b0;
    end else begin
      r_wptr     <= w_wptr_nxt;
      r_rptr     <= w_rptr_nxt;
      r_empty    <= w_empty_nxt;
      r_full     <= w_full_nxt;
      r_dout_vld <= w_rd;
      if (w_rd)    r_dout       <= r_mem[r_rptr[AW-1:0]];
      if (w_drop)  r_ovf        <= 1'b1;
      if (w_count) r_sample_cnt <= r_sample_cnt + LP_ONE;
      r_end_sim <= (w_state_nxt == S_DONE);
    end
  end

  assign DOUT       = r_dout;
  assign DOUT_VALID = r_dout_vld;
  assign EMPTY      = r_empty;
  assign FULL       = r_full;
  assign OVERFLOW   = r_ovf;
  assign SAMPLE_CNT = r_sample_cnt;
  assign END_SIM    = r_end_sim;

`ifdef FPSINK_CLASS_EN
  logic             w_exp_ones;
  logic             w_exp_zero;
  logic             w_mant_zero;
  logic [CNT_W-1:0] r_nan_cnt;
  logic [CNT_W-1:0] r_inf_cnt;
  logic [CNT_W-1:0] r_zero_cnt;

  assign w_exp_ones  = (DIN[30:23] == 8'hFF);
  assign w_exp_zero  = (DIN[30:23] == 8'h00);
  assign w_mant_zero = (DIN[22:0] == 23'd0);

  // Classification follows the count, so dropped captures are still classified
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_nan_cnt  <= '0;
      r_inf_cnt  <= '0;
      r_zero_cnt <= '0;
    end else if (w_count) begin
      if (w_exp_ones && !w_mant_zero && r_nan_cnt != '1)  r_nan_cnt  <= r_nan_cnt + LP_ONE;
      if (w_exp_ones && w_mant_zero && r_inf_cnt != '1)   r_inf_cnt  <= r_inf_cnt + LP_ONE;
      if (w_exp_zero && w_mant_zero && r_zero_cnt != '1)  r_zero_cnt <= r_zero_cnt + LP_ONE;
    end
  end

  assign NAN_CNT  = r_nan_cnt;
  assign INF_CNT  = r_inf_cnt;
  assign ZERO_CNT = r_zero_cnt;
`endif

endmodule

// File: tb/tb_fpmul_result_sink.sv
// Scoreboard bench for fpmul_result_sink: two instances (default N_SAMPLES and N_SAMPLES=5) driven by directed vectors.
module tb_fpmul_result_sink;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_vin, a_rd, a_dv, a_empty, a_full, a_ovf, a_end;
  logic [31:0] a_din, a_dout;
  logic [15:0] a_cnt;
  logic        b_vin, b_rd, b_dv, b_empty, b_full, b_ovf, b_end;
  logic [31:0] b_din, b_dout;
  logic [15:0] b_cnt;
`ifdef FPSINK_CLASS_EN
  logic [15:0] a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
`endif

  fpmul_result_sink #(.LATENCY(LAT), .DEPTH(16), .N_SAMPLES(10000), .CNT_W(16)) u_dut_a (
    .CLK(clk), .RST(rst), .VIN(a_vin), .DIN(a_din), .RD_EN(a_rd),
    .DOUT(a_dout), .DOUT_VALID(a_dv), .EMPTY(a_empty), .FULL(a_full),
    .OVERFLOW(a_ovf), .SAMPLE_CNT(a_cnt), .END_SIM(a_end)
`ifdef FPSINK_CLASS_EN
    , .NAN_CNT(a_nan), .INF_CNT(a_inf), .ZERO_CNT(a_zero)
`endif
  );

  fpmul_result_sink #(.LATENCY(LAT), .DEPTH(16), .N_SAMPLES(5), .CNT_W(16)) u_dut_b (
    .CLK(clk), .RST(rst), .VIN(b_vin), .DIN(b_din), .RD_EN(b_rd),
    .DOUT(b_dout), .DOUT_VALID(b_dv), .EMPTY(b_empty), .FULL(b_full),
    .OVERFLOW(b_ovf), .SAMPLE_CNT(b_cnt), .END_SIM(b_end)
`ifdef FPSINK_CLASS_EN
    , .NAN_CNT(b_nan), .INF_CNT(b_inf), .ZERO_CNT(b_zero)
`endif
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  logic [31:0] stim[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse VIN once per stim entry; each result appears on DIN LAT slots after its VIN.
  task automatic burst(input bit sel_b, input int rd_slot);
    int n;
    n = stim.size();
    for (int i = 0; i < n + LAT; i++) begin
      tick();
      if (sel_b) begin
        b_vin = (i < n);
        b_din = (i >= LAT) ? stim[i-LAT] : 32'h0;
        b_rd  = (i == rd_slot);
      end else begin
        a_vin = (i < n);
        a_din = (i >= LAT) ? stim[i-LAT] : 32'h0;
        a_rd  = (i == rd_slot);
      end
    end
    tick();
    a_vin = 1'b0; a_rd = 1'b0; b_vin = 1'b0; b_rd = 1'b0;
    stim.delete();
  endtask

  task automatic fill_seq(input logic [31:0] base, input int n, input int npush_a, input int npush_b);
    for (int i = 0; i < n; i++) begin
      stim.push_back(base + 32'(i));
      if (i < npush_a) exp_a.push_back(base + 32'(i));
      if (i < npush_b) exp_b.push_back(base + 32'(i));
    end
  endtask

  task automatic drain_a();
    a_rd = 1'b1;
    for (int k = 0; k < 40 && exp_a.size() > 0; k++) tick();
    a_rd = 1'b0;
    tick(); tick();
    chk("drain_a_left", 32'(exp_a.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && a_dv) begin
      checks++;
      if (exp_a.size() == 0) begin
        failures++;
        $display("FAIL a_unexpected_read actual=%h required=no_read", a_dout);
      end else begin
        logic [31:0] e;
        e = exp_a.pop_front();
        if (a_dout !== e) begin
          failures++;
          $display("FAIL a_dout actual=%h required=%h", a_dout, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_dv) begin
      checks++;
      if (exp_b.size() == 0) begin
        failures++;
        $display("FAIL b_unexpected_read actual=%h required=no_read", b_dout);
      end else begin
        logic [31:0] e;
        e = exp_b.pop_front();
        if (b_dout !== e) begin
          failures++;
          $display("FAIL b_dout actual=%h required=%h", b_dout, e);
        end
      end
    end
  end

  // END_SIM must rise exactly when SAMPLE_CNT reaches 5 on the short instance
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (b_end !== (b_cnt == 16'd5)) begin
        failures++;
        $display("FAIL b_end_sim_align actual=%b required=%b cnt=%0d", b_end, (b_cnt == 16'd5), b_cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_vin = 0; a_din = 0; a_rd = 0;
    b_vin = 0; b_din = 0; b_rd = 0;
    #2;
    chk("rst_dout", a_dout, 32'h0);
    chk("rst_dv", 32'(a_dv), 32'd0);
    chk("rst_empty", 32'(a_empty), 32'd1);
    chk("rst_full", 32'(a_full), 32'd0);
    chk("rst_ovf", 32'(a_ovf), 32'd0);
    chk("rst_cnt", 32'(a_cnt), 32'd0);
    chk("rst_end", 32'(a_end), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // single capture then read
    stim.push_back(32'h40C00000);
    exp_a.push_back(32'h40C00000);
    burst(1'b0, -1);
    chk("t1_cnt", 32'(a_cnt), 32'd1);
    chk("t1_empty", 32'(a_empty), 32'd0);
    tick();
    a_rd = 1'b1;
    tick();
    a_rd = 1'b0;
    tick(); tick();
    chk("t1_drained", 32'(exp_a.size()), 32'd0);
    chk("t1_empty_after", 32'(a_empty), 32'd1);
    a_rd = 1'b1;
    tick(); tick();
    a_rd = 1'b0;
    tick();
    chk("t1_dout_hold", a_dout, 32'h40C00000);

    rst = 1'b1; tick(); rst = 1'b0; tick();

    // fill to 16
    fill_seq(32'h00000100, 16, 16, 0);
    burst(1'b0, -1);
    chk("t2_full", 32'(a_full), 32'd1);
    chk("t2_ovf", 32'(a_ovf), 32'd0);
    chk("t2_cnt", 32'(a_cnt), 32'd16);
    chk("t2_empty", 32'(a_empty), 32'd0);

    // capture and read on the same edge while full
    stim.push_back(32'hABCD0001);
    exp_a.push_back(32'hABCD0001);
    burst(1'b0, LAT);
    chk("t3_full", 32'(a_full), 32'd1);
    chk("t3_ovf", 32'(a_ovf), 32'd0);
    chk("t3_cnt", 32'(a_cnt), 32'd17);

    // capture while full with no read is dropped but counted
    stim.push_back(32'hDEAD0000);
    burst(1'b0, -1);
    chk("t4_ovf", 32'(a_ovf), 32'd1);
    chk("t4_cnt", 32'(a_cnt), 32'd18);
    chk("t4_full", 32'(a_full), 32'd1);
    drain_a();
    chk("t4_empty", 32'(a_empty), 32'd1);
    chk("t4_full_after", 32'(a_full), 32'd0);
    chk("t4_ovf_sticky", 32'(a_ovf), 32'd1);

    // END_SIM after 5 of 7 captures
    fill_seq(32'h00000200, 7, 0, 5);
    burst(1'b1, -1);
    chk("t5_end", 32'(b_end), 32'd1);
    chk("t5_cnt", 32'(b_cnt), 32'd5);
    chk("t5_ovf", 32'(b_ovf), 32'd0);
    b_rd = 1'b1;
    repeat (12) tick();
    b_rd = 1'b0;
    tick(); tick();
    chk("t5_drained", 32'(exp_b.size()), 32'd0);
    chk("t5_empty", 32'(b_empty), 32'd1);
    chk("t5_end_hold", 32'(b_end), 32'd1);

    // reset while a VIN pulse is in flight
    a_vin = 1'b1;
    tick();
    a_vin = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("t6_async_dout", a_dout, 32'h0);
    chk("t6_async_empty", 32'(a_empty), 32'd1);
    chk("t6_async_ovf", 32'(a_ovf), 32'd0);
    tick();
    rst = 1'b0;
    repeat (8) tick();
    chk("t6_cnt", 32'(a_cnt), 32'd0);
    chk("t6_empty", 32'(a_empty), 32'd1);
    chk("t6_full", 32'(a_full), 32'd0);
    chk("t6_dout", a_dout, 32'h0);
    chk("t6_dv", 32'(a_dv), 32'd0);
    chk("t6_end", 32'(a_end), 32'd0);
    chk("t6_b_end", 32'(b_end), 32'd0);

`ifdef FPSINK_CLASS_EN
    stim.push_back(32'h7FC00000); exp_a.push_back(32'h7FC00000);
    stim.push_back(32'h7F800000); exp_a.push_back(32'h7F800000);
    stim.push_back(32'h80000000); exp_a.push_back(32'h80000000);
    stim.push_back(32'h3F800000); exp_a.push_back(32'h3F800000);
    burst(1'b0, -1);
    chk("t7_nan", 32'(a_nan), 32'd1);
    chk("t7_inf", 32'(a_inf), 32'd1);
    chk("t7_zero", 32'(a_zero), 32'd1);
    chk("t7_cnt", 32'(a_cnt), 32'd4);
    drain_a();
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
